// File: rtl/spi_proto_bridge_if.sv
// Bundle of SPI byte-slave and protocol-wrapper client signals around spi_proto_bridge.
// The bridge uses the master modport; the surrounding SPI slave and clients use slave.
interface spi_proto_bridge_if #(
    parameter int N_CLIENTS = 2
);
    logic [7:0]             sb_rx_data;
    logic                   sb_rx_stb;
    logic                   sb_cs_start;
    logic                   sb_cs_end;
    logic [7:0]             sb_tx_data;
    logic                   sb_tx_valid;
    logic                   sb_tx_ack;
    logic [7:0]             pw_wdata;
    logic                   pw_wcmd;
    logic                   pw_wstb;
    logic                   pw_end;
    logic [N_CLIENTS-1:0]   pw_req;
    logic [N_CLIENTS-1:0]   pw_gnt;
    logic [8*N_CLIENTS-1:0] pw_rdata;
    logic [N_CLIENTS-1:0]   pw_rstb;
    logic                   tx_ovf;

    modport master (
        input  sb_rx_data, sb_rx_stb, sb_cs_start, sb_cs_end, sb_tx_ack,
        input  pw_req, pw_rdata, pw_rstb,
        output sb_tx_data, sb_tx_valid,
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt, tx_ovf
    );

    modport slave (
        output sb_rx_data, sb_rx_stb, sb_cs_start, sb_cs_end, sb_tx_ack,
        output pw_req, pw_rdata, pw_rstb,
        input  sb_tx_data, sb_tx_valid,
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt, tx_ovf
    );
endinterface

// File: rtl/spi_proto_bridge.sv
// Bridges an SPI byte-level slave to N protocol-wrapper clients: broadcasts received
// bytes, arbitrates one responder per transaction and queues its bytes in a FWFT FIFO.
module spi_proto_bridge #(
    parameter int N_CLIENTS = 2,
    parameter int TX_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_proto_bridge_if.master bus
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] FULL_CNT = TX_DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic in_txn;
    logic txn_close;
    logic fwd;

    assign in_txn    = (state_q != IDLE);
    // A start inside a transaction closes it first, exactly like an explicit end.
    assign txn_close = in_txn && (bus.sb_cs_end || bus.sb_cs_start);
    assign fwd       = in_txn && bus.sb_rx_stb;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.sb_cs_start) state_d = CMD;
            end
            CMD: begin
                if (bus.sb_cs_start)    state_d = CMD;
                else if (bus.sb_cs_end) state_d = IDLE;
                else if (bus.sb_rx_stb) state_d = DATA;
            end
            DATA: begin
                if (bus.sb_cs_start)    state_d = CMD;
                else if (bus.sb_cs_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [7:0] wdata_q;
    logic       wcmd_q;
    logic       wstb_q;
    logic       end_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wdata_q <= 8'h00;
            wcmd_q  <= 1'b0;
            wstb_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wstb_q  <= fwd;
            wcmd_q  <= fwd && (state_q == CMD);
            end_q   <= txn_close;
            if (fwd) wdata_q <= bus.sb_rx_data;
        end
    end

    assign bus.pw_wdata = wdata_q;
    assign bus.pw_wcmd  = wcmd_q;
    assign bus.pw_wstb  = wstb_q;
    assign bus.pw_end   = end_q;

    logic [N_CLIENTS-1:0] gnt_q;
    logic [N_CLIENTS-1:0] pick;

    // Descending scan so the lowest requesting index is the one left standing.
    always_comb begin
        pick = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (bus.pw_req[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    // Grant is locked for the whole transaction and released the cycle after pw_end.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
        end else if (end_q) begin
            gnt_q <= '0;
        end else if (gnt_q == '0 && in_txn) begin
            gnt_q <= pick;
        end
    end

    assign bus.pw_gnt = gnt_q;

    logic [7:0] g_rdata;
    logic       g_rstb;

    always_comb begin
        g_rdata = 8'h00;
        g_rstb  = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (gnt_q[i]) begin
                g_rdata = bus.pw_rdata[8*i +: 8];
                g_rstb  = bus.pw_rstb[i];
            end
        end
    end

    logic [7:0]    mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = bus.sb_tx_ack && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = g_rstb && !end_q && (!full || pop);
    assign drop    = g_rstb && !end_q && full && !pop;

    always_ff @(posedge clk) begin
        if (rst || end_q) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= g_rdata;
    end

    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst || bus.sb_cs_start) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.tx_ovf      = ovf_q;
    assign bus.sb_tx_valid = !empty;
    // Head is masked while empty so stale storage never leaks onto the bus.
    assign bus.sb_tx_data  = empty ? 8'h00 : mem[rd_ptr];
endmodule

// File: tb/tb_spi_proto_bridge.sv
// Self-checking bench for spi_proto_bridge: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level model built on a byte queue.
module tb_spi_proto_bridge;
    localparam int N_CLIENTS = 2;
    localparam int TX_DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_proto_bridge_if #(.N_CLIENTS(N_CLIENTS)) bus ();

    spi_proto_bridge #(
        .N_CLIENTS(N_CLIENTS),
        .TX_DEPTH (TX_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model state: open transaction flag, first-byte flag, granted index, response queue.
    byte unsigned q[$];
    int           gnt_idx;
    bit           in_txn;
    bit           first;
    bit           exp_wstb;
    bit           exp_wcmd;
    bit           exp_end;
    bit           exp_ovf;
    logic [7:0]   exp_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_step();
        bit           end_cur;
        bit           pop;
        bit           push;
        bit           drop;
        byte unsigned pushed;
        if (rst) begin
            q.delete();
            gnt_idx   = -1;
            in_txn    = 1'b0;
            first     = 1'b0;
            exp_wstb  = 1'b0;
            exp_wcmd  = 1'b0;
            exp_end   = 1'b0;
            exp_ovf   = 1'b0;
            exp_wdata = 8'h00;
            return;
        end
        end_cur = exp_end;
        pop     = bus.sb_tx_ack && (q.size() != 0);
        push    = 1'b0;
        pushed  = 8'h00;
        drop    = 1'b0;
        if (gnt_idx >= 0) begin
            push   = bus.pw_rstb[gnt_idx];
            pushed = bus.pw_rdata[8*gnt_idx +: 8];
        end
        if (end_cur) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < TX_DEPTH) q.push_back(pushed);
                else drop = 1'b1;
            end
        end
        if (bus.sb_cs_start) exp_ovf = 1'b0;
        else if (drop)       exp_ovf = 1'b1;

        if (end_cur) begin
            gnt_idx = -1;
        end else if (gnt_idx < 0 && in_txn) begin
            for (int i = N_CLIENTS - 1; i >= 0; i--) if (bus.pw_req[i]) gnt_idx = i;
        end

        exp_wstb = in_txn && bus.sb_rx_stb;
        exp_wcmd = exp_wstb && first;
        if (exp_wstb) exp_wdata = bus.sb_rx_data;
        exp_end = in_txn && (bus.sb_cs_start || bus.sb_cs_end);

        if (bus.sb_cs_start)     begin in_txn = 1'b1; first = 1'b1; end
        else if (bus.sb_cs_end)  in_txn = 1'b0;
        else if (bus.sb_rx_stb)  first = 1'b0;
    endtask

    task automatic compare_all();
        check("wstb",     bus.pw_wstb,     exp_wstb);
        check("wcmd",     bus.pw_wcmd,     exp_wcmd);
        check("wdata",    bus.pw_wdata,    exp_wdata);
        check("end",      bus.pw_end,      exp_end);
        check("gnt",      bus.pw_gnt,      (gnt_idx < 0) ? 32'd0 : (32'd1 << gnt_idx));
        check("tx_valid", bus.sb_tx_valid, q.size() != 0);
        check("tx_data",  bus.sb_tx_data,  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check("tx_ovf",   bus.tx_ovf,      exp_ovf);
    endtask

    // Inputs are set before calling; the model advances, one clock passes, outputs are
    // compared on the falling edge, then the one-cycle pulse inputs drop back to zero.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        bus.sb_rx_stb   = 1'b0;
        bus.sb_cs_start = 1'b0;
        bus.sb_cs_end   = 1'b0;
        bus.sb_tx_ack   = 1'b0;
        bus.pw_rstb     = '0;
    endtask

    byte unsigned vals[5];

    initial begin
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus.sb_rx_data  = 8'h00;
        bus.sb_rx_stb   = 1'b0;
        bus.sb_cs_start = 1'b0;
        bus.sb_cs_end   = 1'b0;
        bus.sb_tx_ack   = 1'b0;
        bus.pw_req      = '0;
        bus.pw_rdata    = '0;
        bus.pw_rstb     = '0;
        rst             = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        check("rst_outputs", {bus.pw_wstb, bus.pw_end, bus.pw_gnt, bus.sb_tx_valid, bus.tx_ovf}, 0);

        // Byte in IDLE is ignored.
        bus.sb_rx_stb = 1'b1; bus.sb_rx_data = 8'h33; step();
        check("idle_rx_ignored", bus.pw_wstb, 1'b0);

        // Command byte then data byte then end, each one cycle after its input.
        bus.sb_cs_start = 1'b1; step();
        bus.sb_rx_stb = 1'b1; bus.sb_rx_data = 8'hF1; step();
        check("cmd_byte", {bus.pw_wstb, bus.pw_wcmd, bus.pw_wdata}, {2'b11, 8'hF1});
        bus.sb_rx_stb = 1'b1; bus.sb_rx_data = 8'hAA; step();
        check("data_byte", {bus.pw_wstb, bus.pw_wcmd, bus.pw_wdata}, {2'b10, 8'hAA});
        bus.sb_cs_end = 1'b1; step();
        check("end_pulse", bus.pw_end, 1'b1);
        step();
        check("end_one_cycle", bus.pw_end, 1'b0);

        // Both clients request; client 0 wins and keeps the grant after dropping req.
        bus.pw_req = 2'b11; bus.sb_cs_start = 1'b1; step(); step();
        check("arb_lowest", bus.pw_gnt, 2'b01);
        bus.pw_rstb = 2'b10; bus.pw_rdata = 16'h9900; step();
        check("other_client_ignored", bus.sb_tx_valid, 1'b0);
        bus.pw_req = 2'b10; step(); step();
        check("grant_held", bus.pw_gnt, 2'b01);

        // Five pushes into a four-deep FIFO: last byte dropped, overflow flagged.
        for (int i = 0; i < 5; i++) begin
            bus.pw_rdata = {8'h00, vals[i]}; bus.pw_rstb = 2'b01; step();
        end
        check("ovf_set", bus.tx_ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("fifo_order", bus.sb_tx_data, vals[i]);
            bus.sb_tx_ack = 1'b1; step();
        end
        check("fifo_drained", bus.sb_tx_valid, 1'b0);
        bus.sb_tx_ack = 1'b1; step();
        check("ack_empty", {bus.sb_tx_valid, bus.sb_tx_data}, 0);

        // Restart inside a transaction: end pulse, overflow cleared, fresh arbitration.
        bus.pw_req = 2'b01; bus.sb_cs_start = 1'b1; step();
        check("restart_end", {bus.pw_end, bus.tx_ovf}, 2'b10);
        step(); step();
        check("regrant", bus.pw_gnt, 2'b01);
        for (int i = 0; i < 4; i++) begin
            bus.pw_rdata = {8'h00, 8'hA0 + 8'(i)}; bus.pw_rstb = 2'b01; step();
        end
        bus.pw_rdata = {8'h00, 8'hB0}; bus.pw_rstb = 2'b01; bus.sb_tx_ack = 1'b1; step();
        check("full_push_pop_ovf", bus.tx_ovf, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("full_push_pop_data", bus.sb_tx_data, (i == 3) ? 8'hB0 : 8'hA1 + 8'(i));
            bus.sb_tx_ack = 1'b1; step();
        end
        check("full_push_pop_empty", bus.sb_tx_valid, 1'b0);

        // Last byte coincident with end; FIFO flushed and a strobe in the end cycle discarded.
        bus.pw_rstb = 2'b01; bus.pw_rdata = 16'h0077; step();
        bus.sb_rx_stb = 1'b1; bus.sb_rx_data = 8'h01; step();
        bus.sb_rx_stb = 1'b1; bus.sb_rx_data = 8'h5A; bus.sb_cs_end = 1'b1; step();
        check("rx_with_end", {bus.pw_wstb, bus.pw_end, bus.pw_wdata}, {2'b11, 8'h5A});
        bus.pw_rstb = 2'b01; step();
        check("flush_on_end", bus.sb_tx_valid, 1'b0);

        // Reset mid-transaction with two queued bytes.
        bus.sb_cs_start = 1'b1; step(); step();
        bus.sb_rx_stb = 1'b1; bus.sb_rx_data = 8'h10; step();
        bus.pw_rstb = 2'b01; bus.pw_rdata = 16'h00C1; step();
        bus.pw_rstb = 2'b01; bus.pw_rdata = 16'h00C2; step();
        check("pre_reset_valid", bus.sb_tx_valid, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_reset_all_zero",
              {bus.pw_wstb, bus.pw_wcmd, bus.pw_end, bus.pw_gnt, bus.sb_tx_valid,
               bus.tx_ovf, bus.pw_wdata, bus.sb_tx_data}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_end_after_reset", bus.pw_end, 1'b0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            bus.sb_cs_start = ($urandom_range(15) == 0);
            bus.sb_cs_end   = ($urandom_range(11) == 0);
            bus.sb_rx_stb   = ($urandom_range(2) == 0);
            bus.sb_rx_data  = 8'($urandom);
            bus.sb_tx_ack   = ($urandom_range(2) == 0);
            bus.pw_req      = N_CLIENTS'($urandom);
            bus.pw_rstb     = N_CLIENTS'($urandom);
            bus.pw_rdata    = (8*N_CLIENTS)'($urandom);
            rst             = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_proto_bridge.md
SPI_PROTO_BRIDGE -- requirements
Module: spi_proto_bridge

Interface
REQ-001 Parameter N_CLIENTS, default 2: number of protocol-wrapper clients, range 1..8.
REQ-002 Parameter TX_DEPTH, default 4: response FIFO depth, power of two, range 2..16.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sb_rx_data  in  8  byte received from the SPI byte-level slave.
REQ-006 sb_rx_stb  in  1  one-cycle strobe; sb_rx_data is valid.
REQ-007 sb_cs_start  in  1  one-cycle pulse on chip-select assertion.
REQ-008 sb_cs_end  in  1  one-cycle pulse on chip-select deassertion.
REQ-009 sb_tx_data  out  8  next response byte for the SPI slave.
REQ-010 sb_tx_valid  out  1  sb_tx_data is valid; FIFO is not empty.
REQ-011 sb_tx_ack  in  1  SPI slave consumed sb_tx_data this cycle.
REQ-012 pw_wdata  out  8  byte broadcast to all clients.
REQ-013 pw_wcmd  out  1  the current pw_wdata is the first byte of the transaction.
REQ-014 pw_wstb  out  1  one-cycle write strobe, broadcast.
REQ-015 pw_end  out  1  one-cycle transaction-end pulse, broadcast.
REQ-016 pw_req  in  N_CLIENTS  per-client response request.
REQ-017 pw_gnt  out  N_CLIENTS  one-hot or zero grant.
REQ-018 pw_rdata  in  8*N_CLIENTS  per-client response byte; client i occupies bits [8i+7:8i].
REQ-019 pw_rstb  in  N_CLIENTS  per-client response strobe.
REQ-020 tx_ovf  out  1  sticky flag; a response byte was dropped in the current transaction.

Function
REQ-021 The state machine SHALL have states IDLE, CMD, DATA; the reset state is IDLE.
- IDLE->CMD on sb_cs_start.
- CMD->DATA on the first sb_rx_stb.
- CMD/DATA->IDLE on sb_cs_end.
REQ-022 On each sb_rx_stb in CMD or DATA, the block SHALL drive pw_wdata=sb_rx_data and pw_wstb=1 on the next cycle (registered, latency 1).
REQ-023 In that cycle, pw_wcmd SHALL be 1 iff the byte was received in CMD, and 0 otherwise.
REQ-024 sb_rx_stb in IDLE SHALL be ignored; no pw_wstb is generated.
REQ-025 sb_cs_end in CMD or DATA SHALL produce pw_end=1 for exactly one cycle, registered with latency 1.
REQ-026 If sb_rx_stb and sb_cs_end occur in the same cycle, the byte SHALL be forwarded, and pw_wstb and pw_end SHALL be asserted in the same output cycle.
REQ-027 sb_cs_start while not in IDLE SHALL be treated as sb_cs_end followed by a new start.
- pw_end is pulsed.
- The state becomes CMD.
REQ-028 Arbitration:
- While pw_gnt==0 and state!=IDLE, the lowest-index asserted pw_req bit SHALL be granted on the next cycle.
- The grant SHALL be held until the cycle after pw_end.
- The grant SHALL then clear to 0.
- No re-arbitration SHALL occur within a transaction.
REQ-029 If the granted client drops pw_req, pw_gnt SHALL still hold until pw_end.
REQ-030 Only the granted client's pw_rstb/pw_rdata SHALL be written to the TX FIFO; strobes from other clients are ignored.
REQ-031 The TX FIFO SHALL be first-word-fall-through: sb_tx_data is the head entry and sb_tx_valid=!empty; sb_tx_ack with sb_tx_valid=1 pops the head.
REQ-032 An ack while empty SHALL be ignored, with no pointer change.
REQ-033 A write while full SHALL drop the byte and set tx_ovf.
- If a pop occurs in the same cycle, the write SHALL succeed and tx_ovf SHALL not be set.
REQ-034 Simultaneous push and pop on a non-empty FIFO SHALL keep the occupancy constant.
- Pointers are log2(TX_DEPTH) bits and wrap modulo TX_DEPTH.
- Occupancy is log2(TX_DEPTH)+1 bits.
REQ-035 The FIFO SHALL be flushed (empty) in the cycle pw_end is asserted; a response strobe in that same cycle is discarded.
REQ-036 tx_ovf SHALL clear on sb_cs_start and on rst.

Reset
REQ-037 On rst, the following SHALL hold on the next cycle, regardless of the current state or any transaction in progress:
- state=IDLE;
- pw_wstb=0, pw_wcmd=0, pw_end=0, pw_gnt=0, pw_wdata=0x00;
- FIFO empty, sb_tx_valid=0, sb_tx_data=0x00, tx_ovf=0.
REQ-038 A reset mid-transaction SHALL NOT emit pw_end.

Verification
REQ-039 cs_start, then rx bytes 0xF1, 0xAA, then cs_end -> pw_wstb with 0xF1 and wcmd=1, then 0xAA with wcmd=0, then one pw_end pulse; each output appears 1 cycle after its input.
REQ-040 pw_req=2'b11 after cs_start -> pw_gnt=2'b01 held to pw_end; client 1's pw_rstb is ignored.
REQ-041 Granted client strobes 0x11, 0x22, 0x33, 0x44, 0x55 with no ack (TX_DEPTH=4) -> FIFO holds 0x11..0x44, tx_ovf=1; acks then yield 0x11..0x44, then sb_tx_valid=0.
REQ-042 Full FIFO with push and ack in the same cycle -> occupancy stays 4, tx_ovf stays 0.
REQ-043 sb_rx_stb with 0x5A coincident with sb_cs_end -> pw_wstb and pw_end in the same cycle; the FIFO is empty on the next cycle.
REQ-044 rst asserted in DATA with 2 FIFO entries -> on the next cycle all outputs are 0, and no pw_end is emitted.
